// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared types and sizing helpers for the APB-to-SRAM bridges.
package apb_sram_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

    localparam int RD_LAT_MAX = 4;

    function automatic int strb_count(input int dw);
        return dw / 8;
    endfunction

    function automatic int boff_width(input int dw);
        return $clog2(dw / 8);
    endfunction
endpackage

// File: rtl/apb_sram_addr_decode.sv
// apb_sram_addr_decode: maps an APB byte address onto an SRAM word address
// and flags out-of-window or misaligned accesses.
module apb_sram_addr_decode
    import apb_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic [ADDR_WIDTH-1:0]        paddr,
    output logic [$clog2(MEM_DEPTH)-1:0] word_addr,
    output logic                         err_range,
    output logic                         err_align
);
    localparam int NS   = strb_count(DATA_WIDTH);
    localparam int BOFF = boff_width(DATA_WIDTH);
    localparam int AW   = $clog2(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;

    assign offset    = paddr - BASE_ADDR;
    assign word      = offset >> BOFF;
    assign word_addr = word[AW-1:0];
    assign err_range = (paddr < BASE_ADDR) || (word >= ADDR_WIDTH'(MEM_DEPTH));
    // Masking instead of slicing keeps this valid for byte-wide memories.
    assign err_align = (offset & ADDR_WIDTH'(NS - 1)) != '0;
endmodule

// File: rtl/apb4_to_sram.sv
// apb4_to_sram: APB4 completer in front of a single-port synchronous SRAM,
// with byte strobes, a relocatable window and configurable read latency.
module apb4_to_sram
    import apb_sram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [ADDR_WIDTH-1:0]        PADDR,
    input  logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH/8-1:0]      PSTRB,
    output logic [DATA_WIDTH-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [$clog2(MEM_DEPTH)-1:0] SRAM_ADDR,
    output logic                         SRAM_CE,
    output logic [DATA_WIDTH/8-1:0]      SRAM_WE,
    output logic [DATA_WIDTH-1:0]        SRAM_WDATA,
    input  logic [DATA_WIDTH-1:0]        SRAM_RDATA
);
    localparam int NS = strb_count(DATA_WIDTH);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(RD_LAT_MAX + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d, wdata_q, wdata_d;
    logic            pready_q, pready_d, pslverr_q, pslverr_d, ce_q, ce_d;
    logic [AW-1:0]   addr_q, addr_d, word_addr;
    logic [NS-1:0]   we_q, we_d;
    logic            err_range, err_align;

    apb_sram_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .paddr    (PADDR),
        .word_addr(word_addr),
        .err_range(err_range),
        .err_align(err_align)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        addr_d    = addr_q;
        ce_d      = 1'b0;
        we_d      = '0;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: if (PSEL && !PENABLE) begin
                if (err_range || err_align) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end else begin
                    state_d = PWRITE ? WRITE : READ;
                    cnt_d   = '0;
                    ce_d    = !PWRITE || (|PSTRB);
                    we_d    = PWRITE ? PSTRB : '0;
                    addr_d  = ce_d ? word_addr : addr_q;
                    wdata_d = ce_d ? PWDATA : wdata_q;
                end
            end
            WRITE: begin
                state_d  = PSEL ? RESP : IDLE;
                pready_d = PSEL;
            end
            READ: if (!PSEL) begin
                state_d = IDLE;
            end else if (cnt_q == CW'(RD_LATENCY)) begin
                state_d  = RESP;
                pready_d = 1'b1;
                prdata_d = SRAM_RDATA;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            addr_q    <= '0;
            ce_q      <= 1'b0;
            we_q      <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            addr_q    <= addr_d;
            ce_q      <= ce_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    assign PRDATA     = prdata_q;
    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;
    assign SRAM_ADDR  = addr_q;
    assign SRAM_CE    = ce_q;
    assign SRAM_WE    = we_q;
    assign SRAM_WDATA = wdata_q;
endmodule

// File: doc/apb4_to_sram.md
Name: apb4_to_sram

Overview:
- APB4 completer bridging one APB port to a single-port synchronous SRAM macro.
- Successor to the APB3 SRAM bridge, adding:
  - PSTRB byte-lane writes
  - a relocatable base address
  - parametrised SRAM read latency
  - alignment and range error reporting with no SRAM side effects
- Sits behind the APB interconnect, in front of a generic SRAM wrapper.

Parameters:
- ADDR_WIDTH, 32: APB address width.
- DATA_WIDTH, 32: APB/SRAM data width; multiple of 8, max 128.
- MEM_DEPTH, 1024: SRAM words; power of two, >= 2.
- BASE_ADDR, 0: byte address of SRAM word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
- RD_LATENCY, 1: cycles from the SRAM_CE sampling edge to valid SRAM_RDATA; range 1..4.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response, valid only while PREADY=1
- SRAM_ADDR  out  clog2(MEM_DEPTH)  word address
- SRAM_CE  out  1  chip enable, active high, one cycle per access
- SRAM_WE  out  DATA_WIDTH/8  per-byte write enable, active high, qualified by SRAM_CE
- SRAM_WDATA  out  DATA_WIDTH  write data
- SRAM_RDATA  in  DATA_WIDTH  read data

Behaviour:
- All outputs are registered. On RST_N low, all outputs are 0 and the FSM is in IDLE.
- Derived values:
  - NUM_STRB = DATA_WIDTH/8
  - BOFF = clog2(NUM_STRB)
  - OFFSET = PADDR - BASE_ADDR, modulo 2^ADDR_WIDTH
- Decode, evaluated in the setup cycle:
  - ERR_RANGE = (PADDR < BASE_ADDR) or (OFFSET >> BOFF) >= MEM_DEPTH
  - ERR_ALIGN = OFFSET[BOFF-1:0] != 0 (never set when NUM_STRB=1)
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - Setup phase (PSEL=1, PENABLE=0) latches the word address (OFFSET >> BOFF), PWDATA, PSTRB and the error flag.
  - If error: go to RESP with PSLVERR=1, PREADY=1 in the first access cycle; no SRAM_CE is asserted.
  - Else if write with PSTRB != 0: go to WRITE with SRAM_CE=1, SRAM_WE=PSTRB in the first access cycle.
  - Else if write with PSTRB == 0: go to WRITE with no SRAM cycle.
  - Else (read): go to READ with SRAM_CE=1, SRAM_WE=0 in the first access cycle.
- WRITE: one cycle, then RESP. PREADY=1 in the 2nd access cycle (1 wait state).
- READ:
  - Counts RD_LATENCY cycles after the CE cycle.
  - Captures SRAM_RDATA into PRDATA in the cycle it is valid.
  - Then RESP. PREADY=1 in access cycle RD_LATENCY+2.
- RESP: PREADY=1 for exactly one cycle, then IDLE. PREADY and PSLVERR are cleared next cycle.
- SRAM_CE and SRAM_WE are high for exactly one cycle per access. SRAM_ADDR and SRAM_WDATA hold their values until the next access.
- PRDATA:
  - Updated only on a successful read.
  - Set to 0 on an error response.
  - Otherwise holds its last value.
- Back-to-back: a new setup phase is accepted in the cycle after the PREADY cycle. There are no idle cycles between transfers.
- Abort (PSEL=0 during WRITE or READ):
  - An SRAM cycle already issued completes.
  - The FSM returns to IDLE without pulsing PREADY.
  - No PRDATA update.
- PENABLE=1 seen in IDLE (protocol violation): ignored, remain IDLE.
- Reset asserted mid-transfer: immediate return to reset values. A partially issued SRAM cycle is the SRAM's responsibility.

Decomposition:
- Package apb_sram_pkg:
  - state enum (IDLE, WRITE, READ, RESP), 2 bits
  - RD_LATENCY upper bound 4
  - function computing strobe count and byte-offset width
- Sub-module apb_sram_addr_decode: combinational OFFSET, word address, ERR_RANGE and ERR_ALIGN from PADDR. Reused by other APB memory bridges.

Test Plan:
Default parameters unless stated.
- Write then read: write PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=0xF; then read 0x10.
  - Write: SRAM_CE=1, SRAM_WE=0xF, SRAM_ADDR=4 in A1; PREADY in A2.
  - Read: PRDATA=0xDEADBEEF with PREADY in A3, PSLVERR=0.
- Byte strobes: write 0x11223344 with PSTRB=0xF to 0x20, then 0xAABBCCDD with PSTRB=0x5.
  - Second write: SRAM_WE=0x5.
  - Read of 0x20 returns 0x11BB33DD (SRAM model).
- Errors:
  - Read PADDR=0x1000 (MEM_DEPTH*4): PREADY=1, PSLVERR=1, PRDATA=0 in A1, no SRAM_CE.
  - Write PADDR=0x6: same response, no SRAM_CE.
- Latency: RD_LATENCY=3, BASE_ADDR=0x4000_0000, read 0x4000_0008.
  - SRAM_ADDR=2.
  - PREADY asserted exactly in access cycle 5.
  - Read PADDR=0x3FFF_FFFC gives PSLVERR=1.
- Back-to-back: three reads and writes with zero idle cycles between them. Each completes with correct data; exactly one SRAM_CE pulse per transfer.
- Abort and reset:
  - PSEL dropped during READ: no PREADY, FSM back to IDLE; the next transfer is correct.
  - RST_N low during WRITE: all outputs 0 asynchronously.
